// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package ssd_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam int DEFAULT_TICK_DIV     = 131072;
    localparam int DEFAULT_BLANK_CYCLES = 256;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/ssd_scan_ctrl_hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed 8-digit common-anode display scanner with per-slot blanking and
// frame-synchronous value update. Define SSD_DP_EN to add per-digit decimal points.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [4*DIGITS-1:0]   data_in,
    output logic                  data_ready,
    input  logic [DIGITS-1:0]     digit_en,
`ifdef SSD_DP_EN
    input  logic [DIGITS-1:0]     dp_mask,
`endif
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            cathode,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    // With no blanking interval every slot opens directly in SHOW.
    localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    logic [CW-1:0]         cnt_reg;
    logic [IW-1:0]         idx_reg;
    state_t                state_reg;
    logic [4*DIGITS-1:0]   staging_reg;
    logic [4*DIGITS-1:0]   shadow_reg;
    logic                  full_reg;
    logic [DIGITS-1:0]     anode_reg;
    logic [6:0]            cathode_reg;
    logic                  frame_done_reg;

    logic                  end_slot;
    logic                  boundary;
    logic [DIGITS-1:0]     show_sel;
    logic [DIGITS-1:0]     anode_next;
    logic [6:0]            seg;
    logic [6:0]            cathode_next;

    assign end_slot = (cnt_reg == SLOT_LAST);
    assign boundary = end_slot && (idx_reg == IDX_LAST);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
            assign show_sel[gi] = (state_reg == SHOW) && (idx_reg == IW'(gi)) && digit_en[gi];
        end
    endgenerate

    assign anode_next = ~show_sel;

    hex7seg u_hex7seg (
        .nibble (shadow_reg[4*idx_reg +: 4]),
        .seg    (seg)
    );

    assign cathode_next = (state_reg == SHOW) ? seg : 7'h7F;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            state_reg      <= SLOT_START;
            staging_reg    <= '0;
            shadow_reg     <= '0;
            full_reg       <= 1'b0;
            anode_reg      <= '1;
            cathode_reg    <= 7'h7F;
            frame_done_reg <= 1'b0;
        end else begin
            if (end_slot) begin
                cnt_reg   <= '0;
                idx_reg   <= idx_reg + 1'b1;
                state_reg <= SLOT_START;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
                if (state_reg == BLANK && cnt_reg == BLANK_LAST) begin
                    state_reg <= SHOW;
                end
            end

            anode_reg      <= anode_next;
            cathode_reg    <= cathode_next;
            frame_done_reg <= boundary;

            // A capture landing on the boundary cycle sees full=0 here, so it waits a frame.
            if (boundary && full_reg) begin
                shadow_reg <= staging_reg;
                full_reg   <= 1'b0;
            end
            if (data_valid && !full_reg) begin
                staging_reg <= data_in;
                full_reg    <= 1'b1;
            end
        end
    end

`ifdef SSD_DP_EN
    logic [DIGITS-1:0] staging_dp_reg;
    logic [DIGITS-1:0] shadow_dp_reg;
    logic              dp_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            staging_dp_reg <= '0;
            shadow_dp_reg  <= '0;
            dp_reg         <= 1'b1;
        end else begin
            dp_reg <= ~(|(show_sel & shadow_dp_reg));
            if (boundary && full_reg) begin
                shadow_dp_reg <= staging_dp_reg;
            end
            if (data_valid && !full_reg) begin
                staging_dp_reg <= dp_mask;
            end
        end
    end

    assign dp = dp_reg;
`else
    assign dp = 1'b1;
`endif

    assign data_ready = !full_reg;
    assign anode      = anode_reg;
    assign cathode    = cathode_reg;
    assign frame_done = frame_done_reg;

endmodule
